btn_debounce: RTL and testbench
===============================

# btn_debounce

Board-input debouncer for the bring-up design: samples N_BTN raw push-button pins, synchronises them into the clk domain, and filters contact bounce. For each button it produces a clean level, one-cycle press and release pulses, and a one-shot long-press pulse. It is the input-side counterpart of the LED blink counter and feeds the board-test logic that drives the LEDs.

## Interface
- N_BTN, 4, number of independent button channels
- DEBOUNCE_CYCLES, 1_000_000, stable-sample count required to accept a level change (10 ms at 100 MHz); must be ≥ 2
- LONG_CYCLES, 100_000_000, hold time after the accepted press that generates btn_long (1 s at 100 MHz); must be ≥ 1
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset rst, synchronous, active-high
- btn_in  in  N_BTN  raw asynchronous button pins, active-high
- btn_level  out  N_BTN  debounced level, 1 = pressed
- btn_press  out  N_BTN  1-cycle pulse on accepted press
- btn_release  out  N_BTN  1-cycle pulse on accepted release
- btn_long  out  N_BTN  1-cycle pulse, at most once per press, when hold reaches LONG_CYCLES

## Operation
- Per channel: 2-flop synchroniser (reset 0), output s. Then an FSM, a counter cnt of width $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1), and a long_done flag. Channels are fully independent.
- RELEASED: cnt=0. On s=1, go to PRESS_CHK with cnt=0.
- PRESS_CHK:
  - s=0: back to RELEASED with no output.
  - s=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, set btn_level=1, pulse btn_press, set cnt=0, long_done=0.
  - Otherwise cnt++.
- PRESSED:
  - s=0: go to RELEASE_CHK with cnt=0.
  - s=1, long_done=0 and cnt==LONG_CYCLES-1: pulse btn_long and set long_done=1.
  - Otherwise cnt++, saturating at its maximum.
- RELEASE_CHK:
  - s=1: back to PRESSED with cnt=0. No pulse. long_done is kept, so a glitch never produces a second btn_long; it only restarts the hold timer.
  - s=0 and cnt==DEBOUNCE_CYCLES-1: go to RELEASED, set btn_level=0, pulse btn_release.
  - Otherwise cnt++.
- Pulse rules:
  - btn_press, btn_release and btn_long are each high for exactly one cycle.
  - btn_press and btn_release never occur in the same cycle on the same channel.
  - btn_long never occurs in the same cycle as btn_press.
- Reset (rst=1 at a posedge):
  - Synchronisers = 0, FSM = RELEASED, cnt = 0, long_done = 0.
  - All outputs = 0 in the following cycle.
  - Reset mid-press produces no btn_release.
  - A button still held after reset is detected as a new press.

## Timing
- All outputs are registered. There is no combinational path from btn_in to any output.
- Press latency: btn_in sampled high at edges 0 … DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 consecutive edges. btn_level and btn_press go high right after edge DEBOUNCE_CYCLES+2.
- Release latency: symmetric. btn_in is sampled low for DEBOUNCE_CYCLES+3 consecutive edges, then btn_release pulses and btn_level falls.
- Any opposite sample inside the window restarts the count. The accepted edge is therefore measured from the last transition.
- btn_long occurs exactly LONG_CYCLES cycles after btn_press when there is no glitch.

## Test plan
(Sim parameters DEBOUNCE_CYCLES=8, LONG_CYCLES=20; edge 0 = first edge sampling the new btn_in value.)
- Clean press, ch0: btn_in[0] goes 0→1 and is held 40 cycles.
  - btn_press[0] and btn_level[0] rise after edge 10.
  - btn_long[0] pulses after edge 30, once only.
  - No other channel toggles.
- Bounce, ch1: btn_in[1] toggles every 3 cycles for 30 cycles, then holds 1. Exactly one btn_press[1], after the 11th consecutive high-sampling edge following the final rise. No btn_release[1].
- Glitch in press, ch2: btn_in[2] is pressed and accepted at cycle 0, then goes low for 4 cycles at cycle 5.
  - btn_level[2] stays 1.
  - No btn_release[2] and no second btn_press[2].
  - btn_long[2] is delayed by the restarted hold timer and still fires exactly once.
- Short press/release, ch3: btn_in[3] is held 15 cycles, then released.
  - btn_press[3] after edge 10.
  - btn_release[3] and btn_level[3]=0 after the 11th low-sampling edge.
  - No btn_long[3].
- All channels: btn_in = 4'b1111 simultaneously. All four btn_press bits pulse in the same cycle.
- Reset mid-press: with btn_level[0]=1, assert rst for 1 cycle while btn_in[0] stays 1.
  - All outputs are 0 the next cycle, with no btn_release pulse.
  - A new btn_press[0] follows 11 edges after rst deasserts.

Source files
------------

// File: rtl/btn_debounce.sv
// Debounces N_BTN push-button pins: each raw pin is synchronised into clk, then
// filtered so that a level change is accepted only after it has been stable for
// DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk, rst     - system clock; synchronous active-high reset
//   btn_in       - raw asynchronous button pins, active-high
//   btn_level    - debounced level per channel, 1 = pressed
//   btn_press    - one-cycle pulse when a press is accepted
//   btn_release  - one-cycle pulse when a release is accepted
//   btn_long     - one-cycle pulse, at most once per press, after LONG_CYCLES of hold
//
// Latency: a change becomes visible DEBOUNCE_CYCLES+3 edges after its first sample.
// That is 2 synchroniser flops, 1 edge to enter the check state, and DEBOUNCE_CYCLES
// edges of stable samples.
// Backpressure: none. Every output is a registered level or pulse.
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]    sync;
        logic          s;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          long_done;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;

        assign s = sync[1];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync      <= 2'b00;
                state     <= RELEASED;
                cnt       <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync      <= {sync[0], btn_in[i]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;

                case (state)
                    RELEASED: begin
                        cnt <= '0;
                        if (s) state <= PRESS_CHK;
                    end

                    PRESS_CHK: begin
                        if (!s) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state     <= PRESSED;
                            level_q   <= 1'b1;
                            press_q   <= 1'b1;
                            cnt       <= '0;
                            long_done <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    PRESSED: begin
                        if (!s) begin
                            state <= RELEASE_CHK;
                            cnt   <= '0;
                        end else begin
                            if (!long_done && cnt == LONG_LAST) begin
                                long_q    <= 1'b1;
                                long_done <= 1'b1;
                            end
                            // Saturate so a very long hold cannot wrap and re-arm the compare.
                            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        end
                    end

                    RELEASE_CHK: begin
                        if (s) begin
                            // A release glitch only restarts the hold timer.
                            // long_done is kept so btn_long cannot fire twice.
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state     <= RELEASED;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    localparam int N   = 4;
    localparam int DEB = 8;
    localparam int LNG = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int total = 0;
    int fails = 0;

    // Pulse counters per channel.
    // Each counter samples the outputs of the previous edge at every posedge.
    logic clr;
    int   press_cnt   [N];
    int   release_cnt [N];
    int   long_cnt    [N];
    int   rule_viol;

    btn_debounce #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (clr) begin
                press_cnt[i]   = 0;
                release_cnt[i] = 0;
                long_cnt[i]    = 0;
            end else begin
                if (btn_press[i])   press_cnt[i]++;
                if (btn_release[i]) release_cnt[i]++;
                if (btn_long[i])    long_cnt[i]++;
            end
        end
        if (clr) rule_viol = 0;
        else if (((btn_press & btn_release) != '0) || ((btn_press & btn_long) != '0)) rule_viol++;
    end

    // One tick moves past exactly one posedge.
    // Inputs are driven and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        clr    = 1'b1;
        rst    = 1'b1;
        btn_in = '0;
        tick(3);
        chk("reset_level",   32'(btn_level),   0);
        chk("reset_press",   32'(btn_press),   0);
        chk("reset_release", 32'(btn_release), 0);
        chk("reset_long",    32'(btn_long),    0);
        rst = 1'b0;
        tick(3);
        clear_counts();

        // ch0: clean press. Edge 0 is the first posedge after btn_in changes.
        btn_in[0] = 1'b1;
        tick(10);                              // after edge 9
        chk("ch0_press_early", 32'(btn_press[0]), 0);
        chk("ch0_level_early", 32'(btn_level[0]), 0);
        tick(1);                               // after edge 10
        chk("ch0_press",       32'(btn_press[0]), 1);
        chk("ch0_level",       32'(btn_level[0]), 1);
        tick(1);                               // after edge 11
        chk("ch0_press_1cyc",  32'(btn_press[0]), 0);
        tick(18);                              // after edge 29
        chk("ch0_long_early",  32'(btn_long[0]),  0);
        tick(1);                               // after edge 30
        chk("ch0_long",        32'(btn_long[0]),  1);
        tick(10);                              // held for 40 cycles in total
        chk("ch0_long_once",   32'(long_cnt[0]),  1);
        chk("ch0_press_once",  32'(press_cnt[0]), 1);
        chk("others_press",    32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 0);
        chk("others_level",    32'(btn_level[3:1]), 0);
        btn_in[0] = 1'b0;
        tick(11);                              // release accepted after edge 10
        chk("ch0_release_cnt", 32'(release_cnt[0]), 0);
        chk("ch0_release",     32'(btn_release[0]), 1);
        chk("ch0_level_low",   32'(btn_level[0]),   0);
        tick(5);
        clear_counts();

        // ch1: toggle every 3 cycles for 30 cycles, then hold high.
        for (int j = 0; j < 10; j++) begin
            btn_in[1] = (j % 2 == 0);
            tick(3);
        end
        chk("ch1_bounce_nopress", 32'(press_cnt[1]), 0);
        btn_in[1] = 1'b1;
        tick(10);
        chk("ch1_press_early", 32'(btn_press[1]), 0);
        tick(1);                               // 11th high-sampling edge
        chk("ch1_press",       32'(btn_press[1]), 1);
        tick(5);
        chk("ch1_press_once",  32'(press_cnt[1]),   1);
        chk("ch1_no_release",  32'(release_cnt[1]), 0);
        btn_in[1] = 1'b0;
        tick(16);
        clear_counts();

        // ch2: press accepted at cycle 0, then low for 4 cycles starting at cycle 5.
        btn_in[2] = 1'b1;
        tick(11);                              // after edge 10
        chk("ch2_press",       32'(btn_press[2]), 1);
        tick(4);                               // after edge 14
        btn_in[2] = 1'b0;
        tick(4);                               // low at edges 15..18
        btn_in[2] = 1'b1;
        tick(3);                               // after edge 21: back in the held state
        chk("ch2_level_glitch", 32'(btn_level[2]), 1);
        tick(9);                               // after edge 30: the unglitched long time
        chk("ch2_long_delayed", 32'(btn_long[2]) | 32'(long_cnt[2]), 0);
        tick(10);                              // after edge 40
        chk("ch2_long_early",  32'(btn_long[2]),  0);
        tick(1);                               // after edge 41 = 21 + LNG
        chk("ch2_long",        32'(btn_long[2]),  1);
        chk("ch2_level_hold",  32'(btn_level[2]), 1);
        tick(5);
        chk("ch2_long_once",   32'(long_cnt[2]),    1);
        chk("ch2_press_once",  32'(press_cnt[2]),   1);
        chk("ch2_no_release",  32'(release_cnt[2]), 0);
        btn_in[2] = 1'b0;
        tick(16);
        clear_counts();

        // ch3: held for 15 cycles, then released.
        btn_in[3] = 1'b1;
        tick(11);
        chk("ch3_press",       32'(btn_press[3]), 1);
        tick(4);                               // high at edges 0..14
        btn_in[3] = 1'b0;
        tick(10);
        chk("ch3_release_early", 32'(btn_release[3]), 0);
        chk("ch3_level_still",   32'(btn_level[3]),   1);
        tick(1);                               // 11th low-sampling edge
        chk("ch3_release",     32'(btn_release[3]), 1);
        chk("ch3_level_low",   32'(btn_level[3]),   0);
        tick(30);
        chk("ch3_no_long",     32'(long_cnt[3]), 0);
        clear_counts();

        // All channels pressed together.
        btn_in = 4'b1111;
        tick(10);
        chk("all_press_early", 32'(btn_press), 0);
        tick(1);
        chk("all_press",       32'(btn_press), 32'hF);
        chk("all_level",       32'(btn_level), 32'hF);
        tick(3);

        // Reset mid-press with all buttons still held.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_level",       32'(btn_level),   0);
        chk("rst_press",       32'(btn_press),   0);
        chk("rst_release",     32'(btn_release), 0);
        chk("rst_long",        32'(btn_long),    0);
        tick(10);
        chk("rst_repress_early", 32'(btn_press[0]), 0);
        tick(1);                               // 11 edges after rst is deasserted
        chk("rst_repress",     32'(btn_press[0]), 1);
        tick(2);
        chk("rst_no_release",  32'(release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3]), 0);
        chk("pulse_rules",     32'(rule_viol), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
